// File: rtl/riscv_core_fetch_pc_if.sv
// Fetch-stage bus bundle: predictor lookup, instruction-memory request and
// response, decode handoff and EX redirect. The fetch unit is the master.
interface riscv_core_fetch_pc_if #(
    parameter int PC_LEN   = 64,
    parameter int INST_LEN = 32
);
    logic [PC_LEN-1:0]   o_if_pc;
    logic [PC_LEN-1:0]   i_bp_target;
    logic                i_bp_taken;
    logic                i_bp_valid;
    logic                o_imem_req_valid;
    logic                i_imem_req_ready;
    logic [PC_LEN-1:0]   o_imem_req_addr;
    logic                i_imem_rsp_valid;
    logic [INST_LEN-1:0] i_imem_rsp_data;
    logic                o_id_valid;
    logic                i_id_ready;
    logic [PC_LEN-1:0]   o_id_pc;
    logic [INST_LEN-1:0] o_id_inst;
    logic                o_id_pred_taken;
    logic [PC_LEN-1:0]   o_id_pred_target;
    logic                i_ex_redirect;
    logic [PC_LEN-1:0]   i_ex_redirect_pc;

    modport master (
        output o_if_pc, o_imem_req_valid, o_imem_req_addr,
               o_id_valid, o_id_pc, o_id_inst, o_id_pred_taken, o_id_pred_target,
        input  i_bp_target, i_bp_taken, i_bp_valid, i_imem_req_ready,
               i_imem_rsp_valid, i_imem_rsp_data, i_id_ready,
               i_ex_redirect, i_ex_redirect_pc
    );

    modport slave (
        input  o_if_pc, o_imem_req_valid, o_imem_req_addr,
               o_id_valid, o_id_pc, o_id_inst, o_id_pred_taken, o_id_pred_target,
        output i_bp_target, i_bp_taken, i_bp_valid, i_imem_req_ready,
               i_imem_rsp_valid, i_imem_rsp_data, i_id_ready,
               i_ex_redirect, i_ex_redirect_pc
    );
endinterface

// File: rtl/riscv_core_fetch_pc.sv
// Fetch PC generator with an in-order fetch queue. Each cycle the current PC
// goes to the predictor, the same-cycle prediction picks the next PC, and
// accepted requests allocate a queue slot that the in-order memory response
// later fills. A redirect flushes the queue and counts the responses still in
// flight so they can be discarded when they arrive.
module riscv_core_fetch_pc #(
    parameter int                PC_LEN   = 64,
    parameter int                INST_LEN = 32,
    parameter int                FQ_DEPTH = 4,
    parameter logic [PC_LEN-1:0] RESET_PC = {PC_LEN{1'b0}}
) (
    input logic                   i_clk,
    input logic                   i_rst_n,
    riscv_core_fetch_pc_if.master bus
);
    localparam int PTR_W = $clog2(FQ_DEPTH);
    localparam int CNT_W = $clog2(FQ_DEPTH + 1);

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    typedef struct packed {
        logic [PC_LEN-1:0] pc;
        logic              pred_taken;
        logic [PC_LEN-1:0] pred_target;
    } meta_t;

    logic [PC_LEN-1:0]   pc_q, pc_d;
    ptr_t                wr_ptr_q, wr_ptr_d;
    ptr_t                rsp_ptr_q, rsp_ptr_d;
    ptr_t                rd_ptr_q, rd_ptr_d;
    cnt_t                count_q, count_d;
    cnt_t                pend_q, pend_d;     // allocated, response not yet seen
    cnt_t                drop_q, drop_d;     // flushed responses still to arrive
    logic [FQ_DEPTH-1:0] done_q, done_d;
    meta_t               meta_q [FQ_DEPTH];
    logic [INST_LEN-1:0] inst_q [FQ_DEPTH];

    logic              pred_taken;
    logic [PC_LEN-1:0] next_pc;
    logic              req_valid, fire;
    logic              rsp_take, rsp_drop;
    logic              id_valid, pop;

    assign pred_taken = bus.i_bp_valid & bus.i_bp_taken;
    assign next_pc    = pred_taken ? bus.i_bp_target : pc_q + PC_LEN'(4);

    assign req_valid = i_rst_n & (count_q < cnt_t'(FQ_DEPTH)) & (drop_q == '0)
                     & ~bus.i_ex_redirect;
    assign fire      = req_valid & bus.i_imem_req_ready;
    assign rsp_take  = bus.i_imem_rsp_valid & (drop_q == '0);
    assign rsp_drop  = bus.i_imem_rsp_valid & (drop_q != '0);
    assign id_valid  = i_rst_n & done_q[rd_ptr_q] & (count_q != '0) & ~bus.i_ex_redirect;
    assign pop       = id_valid & bus.i_id_ready;

    // Next-state logic for PC, pointers, occupancy and drop accounting.
    always_comb begin
        // NOTE: every variable gets a default before any branch; a path that
        // leaves one unassigned would infer a latch.
        pc_d      = pc_q;
        wr_ptr_d  = wr_ptr_q;
        rsp_ptr_d = rsp_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        pend_d    = pend_q;
        drop_d    = drop_q;
        done_d    = done_q;
        if (bus.i_ex_redirect) begin
            pc_d      = bus.i_ex_redirect_pc;
            wr_ptr_d  = '0;
            rsp_ptr_d = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
            pend_d    = '0;
            done_d    = '0;
            drop_d    = pend_q - cnt_t'(rsp_take) + drop_q - cnt_t'(rsp_drop);
        end else begin
            if (fire) begin
                pc_d             = next_pc;
                wr_ptr_d         = wr_ptr_q + ptr_t'(1);
                done_d[wr_ptr_q] = 1'b0;
            end
            if (rsp_take) begin
                done_d[rsp_ptr_q] = 1'b1;
                rsp_ptr_d         = rsp_ptr_q + ptr_t'(1);
            end
            if (pop) begin
                done_d[rd_ptr_q] = 1'b0;
                rd_ptr_d         = rd_ptr_q + ptr_t'(1);
            end
            if (rsp_drop) begin
                drop_d = drop_q - cnt_t'(1);
            end
            count_d = count_q + cnt_t'(fire) - cnt_t'(pop);
            pend_d  = pend_q + cnt_t'(fire) - cnt_t'(rsp_take);
        end
    end

    // Control state register with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!i_rst_n) begin
            pc_q      <= RESET_PC;
            wr_ptr_q  <= '0;
            rsp_ptr_q <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            pend_q    <= '0;
            drop_q    <= '0;
            done_q    <= '0;
        end else begin
            pc_q      <= pc_d;
            wr_ptr_q  <= wr_ptr_d;
            rsp_ptr_q <= rsp_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            pend_q    <= pend_d;
            drop_q    <= drop_d;
            done_q    <= done_d;
        end
    end

    // Queue payload: metadata captured at issue, instruction at response.
    always_ff @(posedge i_clk) begin
        // NOTE: payload arrays carry no reset; done_q gates every read, so
        // stale contents are never visible and the storage stays plain RAM.
        if (fire) begin
            meta_q[wr_ptr_q] <= '{pc:          pc_q,
                                  pred_taken:  pred_taken,
                                  pred_target: pred_taken ? next_pc : bus.i_bp_target};
        end
        if (rsp_take && !bus.i_ex_redirect) begin
            inst_q[rsp_ptr_q] <= bus.i_imem_rsp_data;
        end
    end

    assign bus.o_if_pc          = pc_q;
    assign bus.o_imem_req_addr  = pc_q;
    assign bus.o_imem_req_valid = req_valid;
    assign bus.o_id_valid       = id_valid;
    assign bus.o_id_pc          = meta_q[rd_ptr_q].pc;
    assign bus.o_id_pred_taken  = meta_q[rd_ptr_q].pred_taken;
    assign bus.o_id_pred_target = meta_q[rd_ptr_q].pred_target;
    assign bus.o_id_inst        = inst_q[rd_ptr_q];

    // A response is only legal while some request is awaiting one.
    a_rsp_has_owner : assert property (@(posedge i_clk) disable iff (!i_rst_n)
        bus.i_imem_rsp_valid |-> ((pend_q != '0) || (drop_q != '0)));
endmodule

// File: tb/tb_riscv_core_fetch_pc.sv
// Bench for riscv_core_fetch_pc: a directed vector table for the basic fetch
// stream, hand-written redirect/backpressure/wrap sequences, and a long random
// run against a queue-based reference model with an epoch-tagged memory.
module tb_riscv_core_fetch_pc;
    localparam int          PC_LEN   = 64;
    localparam int          INST_LEN = 32;
    localparam int          FQ_DEPTH = 4;
    localparam logic [63:0] RESET_PC = 64'h0;

    logic i_clk   = 1'b0;
    logic i_rst_n = 1'b0;
    always #5 i_clk = ~i_clk;

    riscv_core_fetch_pc_if #(.PC_LEN(PC_LEN), .INST_LEN(INST_LEN)) bus ();

    riscv_core_fetch_pc #(
        .PC_LEN(PC_LEN), .INST_LEN(INST_LEN), .FQ_DEPTH(FQ_DEPTH), .RESET_PC(RESET_PC)
    ) dut (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .bus    (bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [31:0] inst_of(input logic [63:0] a);
        return {a[29:0], 2'b11} ^ 32'h5A5A_0000 ^ a[63:32];
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        logic [63:0] pc;
        logic        taken;
        logic [63:0] target;
        logic [31:0] inst;
        bit          done;
    } fq_ent_t;

    typedef struct {
        logic [63:0] addr;
        int          epoch;
        int          due;
    } mem_t;

    fq_ent_t     mq[$];
    mem_t        mem[$];
    logic [63:0] m_pc;
    int          epoch    = 0;
    int          cyc      = 0;
    int          last_due = 0;
    int          lat      = 1;

    // stimulus for the next cycle
    logic        s_rst_n, s_ready, s_id_ready, s_redirect, s_bp_valid, s_bp_taken;
    logic [63:0] s_redirect_pc, s_bp_target;

    // DUT observations from the last step
    logic        obs_fire, obs_pop, obs_req_valid, obs_id_valid;
    logic [63:0] obs_addr, obs_id_pc;

    // One clock cycle: drive inputs, compare against the model, advance model.
    task automatic step();
        bit   rsp, e_req, e_idv, pt, marked;
        int   stale, due;
        mem_t m;
        @(negedge i_clk);
        rsp = s_rst_n && (mem.size() > 0) && (mem[0].due <= cyc);
        i_rst_n                  = s_rst_n;
        bus.i_imem_req_ready     = s_ready;
        bus.i_id_ready           = s_id_ready;
        bus.i_ex_redirect        = s_redirect;
        bus.i_ex_redirect_pc     = s_redirect_pc;
        bus.i_bp_valid           = s_bp_valid;
        bus.i_bp_taken           = s_bp_taken;
        bus.i_bp_target          = s_bp_target;
        bus.i_imem_rsp_valid     = rsp;
        bus.i_imem_rsp_data      = '0;
        if (rsp) bus.i_imem_rsp_data = inst_of(mem[0].addr);
        #1;
        stale = 0;
        foreach (mem[i]) if (mem[i].epoch != epoch) stale++;
        e_req = s_rst_n && (mq.size() < FQ_DEPTH) && (stale == 0) && !s_redirect;
        e_idv = s_rst_n && (mq.size() > 0) && mq[0].done && !s_redirect;
        check("req_valid", bus.o_imem_req_valid, e_req);
        check("id_valid", bus.o_id_valid, e_idv);
        if (s_rst_n) begin
            check("req_addr", bus.o_imem_req_addr, m_pc);
            check("if_pc", bus.o_if_pc, m_pc);
        end
        if (e_idv) begin
            check("id_pc", bus.o_id_pc, mq[0].pc);
            check("id_inst", bus.o_id_inst, mq[0].inst);
            check("id_taken", bus.o_id_pred_taken, mq[0].taken);
            check("id_target", bus.o_id_pred_target, mq[0].target);
        end
        obs_req_valid = bus.o_imem_req_valid;
        obs_id_valid  = bus.o_id_valid;
        obs_fire      = bus.o_imem_req_valid & s_ready;
        obs_pop       = bus.o_id_valid & s_id_ready;
        obs_addr      = bus.o_imem_req_addr;
        obs_id_pc     = bus.o_id_pc;

        if (!s_rst_n) begin
            mq.delete();
            mem.delete();
            m_pc     = RESET_PC;
            last_due = cyc;
        end else begin
            if (rsp) begin
                m = mem.pop_front();
                marked = 0;
                if (m.epoch == epoch) begin
                    foreach (mq[i]) begin
                        if (!marked && !mq[i].done) begin
                            mq[i].done = 1;
                            mq[i].inst = inst_of(m.addr);
                            marked     = 1;
                        end
                    end
                end
            end
            if (s_redirect) begin
                mq.delete();
                m_pc = s_redirect_pc;
                epoch++;
            end else begin
                pt = s_bp_valid && s_bp_taken;
                if (e_idv && s_id_ready) void'(mq.pop_front());
                if (e_req && s_ready) begin
                    mq.push_back('{m_pc, pt, s_bp_target, 32'h0, 1'b0});
                    due = cyc + lat;
                    if (due <= last_due) due = last_due + 1;
                    last_due = due;
                    mem.push_back('{m_pc, epoch, due});
                    m_pc = pt ? s_bp_target : m_pc + 64'd4;
                end
            end
        end
        cyc++;
    endtask

    task automatic reset_dut();
        s_ready       = 1; s_id_ready = 1; s_redirect = 0; s_redirect_pc = '0;
        s_bp_valid    = 0; s_bp_taken = 0; s_bp_target = '0;
        lat           = 1;
        s_rst_n       = 0;
        repeat (2) step();
        s_rst_n       = 1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        rsp;
        logic [63:0] rsp_pc;
        logic        bp_hit;
        logic [63:0] bp_tgt;
        logic        e_req;
        logic [63:0] e_addr;
        logic        e_idv;
        logic [63:0] e_pc;
        logic        e_tk;
        logic [63:0] e_tg;
    } vec_t;

    function automatic vec_t mk(logic rsp, logic [63:0] rsp_pc, logic bp_hit, logic [63:0] bp_tgt,
                                logic e_req, logic [63:0] e_addr, logic e_idv, logic [63:0] e_pc,
                                logic e_tk, logic [63:0] e_tg);
        return '{rsp, rsp_pc, bp_hit, bp_tgt, e_req, e_addr, e_idv, e_pc, e_tk, e_tg};
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl[7];
        int   n, fires, pops;

        // Fresh reset, memory always ready with 1-cycle response, a taken
        // prediction at PC 0x8 redirecting the stream to 0x100.
        tbl[0] = mk(0, 64'h0,   0, 64'h0,   1, 64'h0,   0, 64'h0,   0, 64'h0);
        tbl[1] = mk(1, 64'h0,   0, 64'h0,   1, 64'h4,   0, 64'h0,   0, 64'h0);
        tbl[2] = mk(1, 64'h4,   1, 64'h100, 1, 64'h8,   1, 64'h0,   0, 64'h0);
        tbl[3] = mk(1, 64'h8,   0, 64'h0,   1, 64'h100, 1, 64'h4,   0, 64'h0);
        tbl[4] = mk(1, 64'h100, 0, 64'h0,   1, 64'h104, 1, 64'h8,   1, 64'h100);
        tbl[5] = mk(1, 64'h104, 0, 64'h0,   1, 64'h108, 1, 64'h100, 0, 64'h0);
        tbl[6] = mk(1, 64'h108, 0, 64'h0,   1, 64'h10C, 1, 64'h104, 0, 64'h0);

        reset_dut();
        foreach (tbl[i]) begin
            @(negedge i_clk);
            i_rst_n              = 1;
            bus.i_imem_req_ready = 1;
            bus.i_id_ready       = 1;
            bus.i_ex_redirect    = 0;
            bus.i_ex_redirect_pc = '0;
            bus.i_imem_rsp_valid = tbl[i].rsp;
            bus.i_imem_rsp_data  = inst_of(tbl[i].rsp_pc);
            bus.i_bp_valid       = tbl[i].bp_hit;
            bus.i_bp_taken       = tbl[i].bp_hit;
            bus.i_bp_target      = tbl[i].bp_tgt;
            #1;
            check($sformatf("vec%0d_req_valid", i), bus.o_imem_req_valid, tbl[i].e_req);
            check($sformatf("vec%0d_req_addr", i), bus.o_imem_req_addr, tbl[i].e_addr);
            check($sformatf("vec%0d_id_valid", i), bus.o_id_valid, tbl[i].e_idv);
            if (tbl[i].e_idv) begin
                check($sformatf("vec%0d_id_pc", i), bus.o_id_pc, tbl[i].e_pc);
                check($sformatf("vec%0d_id_inst", i), bus.o_id_inst, inst_of(tbl[i].e_pc));
                check($sformatf("vec%0d_id_taken", i), bus.o_id_pred_taken, tbl[i].e_tk);
                check($sformatf("vec%0d_id_target", i), bus.o_id_pred_target, tbl[i].e_tg);
            end
        end

        // Decode stalled for 10 cycles: exactly FQ_DEPTH requests, head held.
        reset_dut();
        s_id_ready = 0;
        fires = 0;
        repeat (10) begin
            step();
            fires += int'(obs_fire);
            if (obs_id_valid) check("stall_hold_pc", obs_id_pc, 64'h0);
        end
        check("stall_fires", fires, FQ_DEPTH);
        check("stall_full_req_valid", obs_req_valid, 1'b0);
        s_id_ready = 1;
        pops = 0;
        repeat (4) begin
            step();
            pops += int'(obs_pop);
        end
        check("stall_drain_rate", pops, 4);

        // Three requests in flight, redirect to 0x200: late responses dropped.
        reset_dut();
        lat = 3;
        repeat (3) step();
        s_redirect = 1; s_redirect_pc = 64'h200;
        step();
        check("redir_id_valid", obs_id_valid, 1'b0);
        check("redir_req_valid", obs_req_valid, 1'b0);
        s_redirect = 0;
        n = 0;
        do begin step(); n++; end while (!obs_fire && n < 20);
        check("redir_gap", n, 3);
        check("redir_first_addr", obs_addr, 64'h200);
        n = 0;
        do begin step(); n++; end while (!obs_id_valid && n < 20);
        check("redir_first_id_pc", obs_id_pc, 64'h200);

        // Redirect in the same cycle as a response and a would-be pop.
        reset_dut();
        lat = 2;
        repeat (3) step();
        s_redirect = 1; s_redirect_pc = 64'h300;
        step();
        check("redir2_id_valid", obs_id_valid, 1'b0);
        s_redirect = 0;
        n = 0;
        do begin step(); n++; end while (!obs_fire && n < 20);
        check("redir2_gap", n, 2);
        check("redir2_first_addr", obs_addr, 64'h300);
        n = 0;
        do begin step(); n++; end while (!obs_id_valid && n < 20);
        check("redir2_first_id_pc", obs_id_pc, 64'h300);

        // PC wrap at the top of the address space.
        reset_dut();
        s_redirect = 1; s_redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        step();
        s_redirect = 0;
        step();
        check("wrap_addr_top", obs_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        step();
        check("wrap_addr_zero", obs_addr, 64'h0);

        // Random traffic against the model.
        reset_dut();
        for (int c = 0; c < 3000; c++) begin
            if (c % 500 == 0) lat = int'($urandom_range(1, 4));
            s_rst_n       = ($urandom_range(0, 399) != 0);
            s_ready       = ($urandom_range(0, 3) != 0);
            s_id_ready    = ($urandom_range(0, 3) != 0);
            s_bp_valid    = $urandom_range(0, 1) != 0;
            s_bp_taken    = $urandom_range(0, 1) != 0;
            s_bp_target   = {$urandom, $urandom} & ~64'h3;
            s_redirect    = ($urandom_range(0, 24) == 0);
            s_redirect_pc = {$urandom, $urandom} & ~64'h3;
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
